// File: rtl/ram_sp_rr_arbiter_pkg.sv
// ram_arb_pkg: shared types for the single-port RAM round-robin arbiter.
//   NUM_REQ   - number of requesters sharing the RAM
//   req_id_t  - requester index
//   cmd_t     - one RAM command {wen, bwen, addr, wdata}, sized by CMD_* widths
package ram_arb_pkg;

  localparam int unsigned NUM_REQ        = 2;
  localparam int unsigned CMD_DATA_WIDTH = 32;
  localparam int unsigned CMD_DEPTH      = 16;
  localparam int unsigned CMD_ADDR_WIDTH = $clog2(CMD_DEPTH);
  localparam int unsigned CMD_BWEN_WIDTH = CMD_DATA_WIDTH / 8;

  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

  typedef struct packed {
    logic                      wen;
    logic [CMD_BWEN_WIDTH-1:0] bwen;
    logic [CMD_ADDR_WIDTH-1:0] addr;
    logic [CMD_DATA_WIDTH-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/ram_sp_rr_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a one-bit priority pointer.
//   clock, reset        - clock, asynchronous active-high reset
//   valid_0, valid_1    - request present per requester
//   grant_0, grant_1    - combinational one-hot (or zero) grant, forced 0 in reset
//   grant_id            - index of the granted requester (meaningful with a grant)
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    valid_0,
  input  logic    valid_1,
  output logic    grant_0,
  output logic    grant_1,
  output req_id_t grant_id
);

  req_id_t prio_q, prio_d;

  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (!reset) begin
      if (valid_0 && valid_1) begin
        grant_0 = (prio_q == req_id_t'(0));
        grant_1 = (prio_q == req_id_t'(1));
      end else begin
        grant_0 = valid_0;
        grant_1 = valid_1;
      end
    end
    grant_id = req_id_t'(grant_1);
  end

  // After a grant the pointer moves to the other requester; idle cycles hold it.
  always_comb begin
    prio_d = prio_q;
    if (grant_0) begin
      prio_d = req_id_t'(1);
    end else if (grant_1) begin
      prio_d = req_id_t'(0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/ram_sp_rr_arbiter.sv
// ram_sp_rr_arbiter: shares one single-port byte-masked RAM (registered read)
// between two valid/ready clients with round-robin arbitration.
//   clock, reset                     - clock, asynchronous active-high reset
//   req_valid_x / req_ready_x        - request handshake (ready is the grant)
//   req_wen_x, req_bwen_x,
//   req_addr_x, req_wdata_x          - request payload
//   rsp_valid_x / rsp_rdata_x        - one-cycle read response
//   ram_cen, ram_wen, ram_bwen,
//   ram_addr, ram_din                - RAM command pins (all 0 when idle)
//   ram_dout                         - RAM registered read data
module ram_sp_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CMD_DATA_WIDTH,
  parameter int unsigned DEPTH      = CMD_DEPTH,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
  localparam int unsigned BWEN_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid_0,
  output logic                  req_ready_0,
  input  logic                  req_wen_0,
  input  logic [BWEN_WIDTH-1:0] req_bwen_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  output logic                  rsp_valid_0,
  output logic [DATA_WIDTH-1:0] rsp_rdata_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic                  req_wen_1,
  input  logic [BWEN_WIDTH-1:0] req_bwen_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  rsp_valid_1,
  output logic [DATA_WIDTH-1:0] rsp_rdata_1,
  output logic                  ram_cen,
  output logic                  ram_wen,
  output logic [BWEN_WIDTH-1:0] ram_bwen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  // The command struct is sized by the package; reject mismatched overrides.
  if (DATA_WIDTH != CMD_DATA_WIDTH || DEPTH != CMD_DEPTH) begin : g_bad_cfg
    $error("ram_sp_rr_arbiter: DATA_WIDTH/DEPTH must match ram_arb_pkg CMD_* widths");
  end

  logic    grant_0, grant_1, any_grant;
  req_id_t grant_id;
  cmd_t    cmd_0, cmd_1, cmd_sel;
  logic    pending_q, pending_d;
  req_id_t owner_q, owner_d;

  rr_arb2 u_arb (
    .clock    (clock),
    .reset    (reset),
    .valid_0  (req_valid_0),
    .valid_1  (req_valid_1),
    .grant_0  (grant_0),
    .grant_1  (grant_1),
    .grant_id (grant_id)
  );

  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;

  always_comb begin
    cmd_0     = '{wen: req_wen_0, bwen: req_bwen_0, addr: req_addr_0, wdata: req_wdata_0};
    cmd_1     = '{wen: req_wen_1, bwen: req_bwen_1, addr: req_addr_1, wdata: req_wdata_1};
    any_grant = grant_0 | grant_1;
    cmd_sel   = '0;
    if (grant_0) begin
      cmd_sel = cmd_0;
    end else if (grant_1) begin
      cmd_sel = cmd_1;
    end
    // cmd_sel is all-zero without a grant, so the RAM pins idle at 0.
    ram_cen  = any_grant;
    ram_wen  = cmd_sel.wen;
    ram_bwen = cmd_sel.bwen;
    ram_addr = cmd_sel.addr;
    ram_din  = cmd_sel.wdata;
  end

  // Remember who issued a read so the registered RAM data goes to them next cycle.
  always_comb begin
    pending_d = any_grant && !cmd_sel.wen;
    owner_d   = any_grant ? grant_id : owner_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      owner_q   <= '0;
    end else begin
      pending_q <= pending_d;
      owner_q   <= owner_d;
    end
  end

  assign rsp_valid_0 = pending_q && (owner_q == req_id_t'(0));
  assign rsp_valid_1 = pending_q && (owner_q == req_id_t'(1));
  assign rsp_rdata_0 = ram_dout;
  assign rsp_rdata_1 = ram_dout;

endmodule

// File: tb/tb_ram_sp_rr_arbiter.sv
// Self-checking bench for ram_sp_rr_arbiter with a behavioural RAM macro,
// a reference memory/priority model and a per-cycle response scoreboard.
module tb_ram_sp_rr_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned BW = 4;

  logic          clock, reset;
  logic          req_valid_0, req_ready_0, req_wen_0, rsp_valid_0;
  logic [BW-1:0] req_bwen_0;
  logic [AW-1:0] req_addr_0;
  logic [DW-1:0] req_wdata_0, rsp_rdata_0;
  logic          req_valid_1, req_ready_1, req_wen_1, rsp_valid_1;
  logic [BW-1:0] req_bwen_1;
  logic [AW-1:0] req_addr_1;
  logic [DW-1:0] req_wdata_1, rsp_rdata_1;
  logic          ram_cen, ram_wen;
  logic [BW-1:0] ram_bwen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  ram_sp_rr_arbiter #(.DATA_WIDTH(DW), .DEPTH(16)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid_0 (req_valid_0),
    .req_ready_0 (req_ready_0),
    .req_wen_0   (req_wen_0),
    .req_bwen_0  (req_bwen_0),
    .req_addr_0  (req_addr_0),
    .req_wdata_0 (req_wdata_0),
    .rsp_valid_0 (rsp_valid_0),
    .rsp_rdata_0 (rsp_rdata_0),
    .req_valid_1 (req_valid_1),
    .req_ready_1 (req_ready_1),
    .req_wen_1   (req_wen_1),
    .req_bwen_1  (req_bwen_1),
    .req_addr_1  (req_addr_1),
    .req_wdata_1 (req_wdata_1),
    .rsp_valid_1 (rsp_valid_1),
    .rsp_rdata_1 (rsp_rdata_1),
    .ram_cen     (ram_cen),
    .ram_wen     (ram_wen),
    .ram_bwen    (ram_bwen),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAM macro: byte-masked write, registered read, cleared by reset.
  logic [DW-1:0] ram_mem [16];
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
      ram_dout <= '0;
    end else if (ram_cen) begin
      if (ram_wen) begin
        for (int k = 0; k < 4; k++)
          if (ram_bwen[k]) ram_mem[ram_addr][8*k +: 8] <= ram_din[8*k +: 8];
      end else begin
        ram_dout <= ram_mem[ram_addr];
      end
    end
  end

  // Reference model and scoreboard.
  typedef struct {
    bit            v;
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] ref_mem [16];
  bit            m_prio;
  bit            m_g0, m_g1;
  int            errors = 0;
  int            checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    m_prio = 1'b0;
    sb_q.delete();
  endtask

  task automatic set_idle();
    req_valid_0 = 1'b0; req_wen_0 = 1'b0; req_bwen_0 = '0; req_addr_0 = '0; req_wdata_0 = '0;
    req_valid_1 = 1'b0; req_wen_1 = 1'b0; req_bwen_1 = '0; req_addr_1 = '0; req_wdata_1 = '0;
  endtask

  // Drive one cycle of requests, check grant and RAM command, update the model.
  task automatic issue(input bit v0, input bit w0, input logic [BW-1:0] b0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit v1, input bit w1, input logic [BW-1:0] b1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bit            w;
    logic [BW-1:0] b;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    exp_t          e;
    req_valid_0 = v0; req_wen_0 = w0; req_bwen_0 = b0; req_addr_0 = a0; req_wdata_0 = d0;
    req_valid_1 = v1; req_wen_1 = w1; req_bwen_1 = b1; req_addr_1 = a1; req_wdata_1 = d1;
    #1;
    m_g0 = v0 && (!v1 || m_prio == 1'b0);
    m_g1 = v1 && (!v0 || m_prio == 1'b1);
    check_val("ready_0", req_ready_0, m_g0);
    check_val("ready_1", req_ready_1, m_g1);
    e.v = 1'b0; e.id = 0; e.data = '0;
    if (m_g0 || m_g1) begin
      w = m_g0 ? w0 : w1;
      b = m_g0 ? b0 : b1;
      a = m_g0 ? a0 : a1;
      d = m_g0 ? d0 : d1;
      check_val("ram_cen", ram_cen, 1);
      check_val("ram_wen", ram_wen, w);
      check_val("ram_bwen", ram_bwen, b);
      check_val("ram_addr", ram_addr, a);
      check_val("ram_din", ram_din, d);
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
      end else begin
        e.v = 1'b1; e.id = m_g0 ? 0 : 1; e.data = ref_mem[a];
      end
      m_prio = m_g0;
    end else begin
      check_val("ram_idle", {ram_cen, ram_wen, ram_bwen, ram_addr, ram_din}, 0);
    end
    sb_q.push_back(e);
  endtask

  // After the edge: compare the response against the scoreboard head.
  task automatic retire();
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("rsp_valid_0", rsp_valid_0, e.v && e.id == 0);
      check_val("rsp_valid_1", rsp_valid_1, e.v && e.id == 1);
      if (e.v && e.id == 0) check_val("rsp_rdata_0", rsp_rdata_0, e.data);
      if (e.v && e.id == 1) check_val("rsp_rdata_1", rsp_rdata_1, e.data);
    end
  endtask

  task automatic step(input bit v0, input bit w0, input logic [BW-1:0] b0,
                      input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input bit v1, input bit w1, input logic [BW-1:0] b1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    issue(v0, w0, b0, a0, d0, v1, w1, b1, a1, d1);
    @(posedge clock); #1;
    retire();
  endtask

  task automatic idle_step();
    step(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    bit            hv [2];
    bit            hw [2];
    logic [BW-1:0] hb [2];
    logic [AW-1:0] ha [2];
    logic [DW-1:0] hd [2];

    // Reset with both requesters valid: no grant may leak through.
    reset = 1'b1;
    set_idle();
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    model_reset();
    #12;
    check_val("rst_ready_0", req_ready_0, 0);
    check_val("rst_ready_1", req_ready_1, 0);
    check_val("rst_cen", ram_cen, 0);
    check_val("rst_rsp", {rsp_valid_0, rsp_valid_1}, 0);
    set_idle();
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;

    // Write then read from the other requester.
    step(1, 1, 4'hF, 4'd3, 32'hDEADBEEF, 0, 0, '0, '0, '0);
    step(0, 0, '0, '0, '0, 1, 0, '0, 4'd3, '0);
    idle_step();

    // Partial write.
    step(1, 1, 4'hF, 4'd5, 32'h11223344, 0, 0, '0, '0, '0);
    step(0, 0, '0, '0, '0, 1, 1, 4'b0101, 4'd5, 32'hAABBCCDD);
    step(1, 0, '0, 4'd5, '0, 0, 0, '0, '0, '0);
    idle_step();

    // Both requesters reading continuously: alternating grants.
    for (int i = 0; i < 6; i++) step(1, 0, '0, 4'd3, '0, 1, 0, '0, 4'd5, '0);
    idle_step();

    // Idle gaps hold prio; single request from 0 is granted at once.
    step(1, 0, '0, 4'd3, '0, 0, 0, '0, '0, '0);
    idle_step();
    idle_step();
    step(1, 0, '0, 4'd5, '0, 0, 0, '0, '0, '0);
    step(1, 0, '0, 4'd3, '0, 1, 0, '0, 4'd5, '0);
    idle_step();

    // Back-to-back write then read of the same address.
    step(0, 0, '0, '0, '0, 1, 1, 4'hF, 4'd9, 32'h12345678);
    step(1, 0, '0, 4'd9, '0, 0, 0, '0, '0, '0);
    step(0, 0, '0, '0, '0, 1, 1, 4'b1000, 4'd9, 32'hFF000000);
    step(0, 0, '0, '0, '0, 1, 0, '0, 4'd9, '0);
    idle_step();

    // Random traffic; a blocked requester keeps its payload stable.
    for (int r = 0; r < 2; r++) begin
      hv[r] = 1'b0; hw[r] = 1'b0; hb[r] = '0; ha[r] = '0; hd[r] = '0;
    end
    m_g0 = 1'b0;
    m_g1 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!(hv[r] && !(r == 0 ? m_g0 : m_g1))) begin
          hv[r] = ($urandom_range(0, 3) != 0);
          hw[r] = $urandom_range(0, 1);
          hb[r] = BW'($urandom_range(0, 15));
          ha[r] = AW'($urandom_range(0, 15));
          hd[r] = $urandom;
        end
      end
      step(hv[0], hw[0], hb[0], ha[0], hd[0], hv[1], hw[1], hb[1], ha[1], hd[1]);
    end
    idle_step();

    // Reset right after a read is accepted: the response is dropped.
    issue(1, 0, '0, 4'd9, '0, 0, 0, '0, '0, '0);
    @(posedge clock); #1;
    reset = 1'b1;
    req_valid_1 = 1'b1;
    #1;
    check_val("rstmid_rsp_0", rsp_valid_0, 0);
    check_val("rstmid_rsp_1", rsp_valid_1, 0);
    check_val("rstmid_ready", {req_ready_0, req_ready_1}, 0);
    check_val("rstmid_cen", ram_cen, 0);
    model_reset();
    @(posedge clock); #1;
    check_val("rstmid_rsp_hold", {rsp_valid_0, rsp_valid_1}, 0);
    set_idle();
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    check_val("post_rst_outputs",
              {req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
               ram_cen, ram_wen, ram_bwen, ram_addr, ram_din}, 0);
    step(0, 0, '0, '0, '0, 1, 0, '0, 4'd3, '0);
    step(1, 0, '0, 4'd9, '0, 1, 0, '0, 4'd5, '0);
    step(0, 0, '0, '0, '0, 1, 0, '0, 4'd5, '0);
    idle_step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_sp_rr_arbiter.md
# ram_sp_rr_arbiter

Two-requester round-robin arbiter that shares one single-port byte-masked RAM instance (registered read, byte-write mask) between two independent clients. Each client has a valid/ready request channel and a one-cycle read-response channel. At most one RAM command is issued per cycle. The block sits directly in front of the RAM macro and owns all of its command pins.

## Interface
- DATA_WIDTH, 32, RAM and client data width; multiple of 8
- DEPTH, 16, RAM word count
- ADDR_WIDTH, $clog2(DEPTH), derived (localparam)
- BWEN_WIDTH, DATA_WIDTH/8, derived (localparam)

Ports (x = 0, 1, one set per requester). Reset is `reset`, asynchronous, active-high. Clock is `clock`.
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- req_valid_x  in  1  request present
- req_ready_x  out  1  request accepted this cycle (combinational grant)
- req_wen_x  in  1  1 = write, 0 = read
- req_bwen_x  in  BWEN_WIDTH  byte write enables (writes only)
- req_addr_x  in  ADDR_WIDTH  word address
- req_wdata_x  in  DATA_WIDTH  write data
- rsp_valid_x  out  1  read data valid, one-cycle pulse
- rsp_rdata_x  out  DATA_WIDTH  read data, qualified by rsp_valid_x
- ram_cen  out  1  RAM chip enable
- ram_wen  out  1  RAM write enable
- ram_bwen  out  BWEN_WIDTH  RAM byte enables
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_din  out  DATA_WIDTH  RAM write data
- ram_dout  in  DATA_WIDTH  RAM registered read data

## Operation
- A request transfers when req_valid_x && req_ready_x. At most one req_ready_x is high per cycle.
- Grant selection:
  - Only one valid: that requester is granted.
  - Both valid: the requester indicated by the priority pointer `prio` (1 bit) is granted.
  - Neither valid: no grant, ram_cen = 0.
- `prio` update: after any grant, `prio` points to the requester not granted. With no grant, `prio` holds.
- Granted command is driven combinationally to the RAM in the same cycle:
  - ram_cen = 1
  - ram_wen, ram_bwen, ram_addr, ram_din come from the granted requester
  - When ram_cen = 0, all RAM command outputs are 0.
- Write: no response. Data is in the RAM after the accepting edge.
- Read: a registered owner flag and a pending bit record the read. The next cycle, rsp_valid_x of the owner pulses for exactly one cycle.
- rsp_rdata_0 and rsp_rdata_1 are both wired to ram_dout and are meaningful only while the matching rsp_valid_x is high.
- No response backpressure: clients always sink responses.
- Requesters keep the payload stable while valid and not ready. The arbiter does not check this.
- Reads and writes pipeline back-to-back at one command per cycle. A read issued the cycle after a write to the same address returns the new data.

## Timing
- Reset values: prio = 0 (requester 0 first), pending = 0, rsp_valid_x = 0, ram_cen = 0, req_ready_x = 0.
  - req_ready_x and ram_cen are forced to 0 while reset is high.
- Reset asserted mid-operation: any pending read response is dropped and never reported. The RAM is cleared by the same reset.
- Read latency: request accepted at edge N gives rsp_valid high in the cycle after edge N, sampled at edge N+1.
- Throughput: 1 command per cycle. With both requesters continuously valid, grants alternate 0,1,0,1.
- Worst-case wait for a valid requester is 1 cycle, so there is no starvation.
- Combinational paths: req_valid_x → req_ready_x and → ram_* outputs. ram_dout → rsp_rdata_x.

## Structure
- Package ram_arb_pkg:
  - NUM_REQ = 2
  - req_id_t (1-bit requester index)
  - cmd struct {wen, bwen, addr, wdata}, parameterised by widths via package parameters or macros
- Sub-module rr_arb2: combinational grant from {valid_1, valid_0, prio} plus the registered prio update, with its own clock and reset.
- Top level contains the request mux, the pending/owner registers and the response routing.

## Test plan
- Reset, then req 0 writes 0xDEADBEEF to addr 3 with bwen=4'hF. Next cycle, req 1 reads addr 3 → rsp_valid_1 pulses once with 0xDEADBEEF. rsp_valid_0 stays 0.
- Both requesters hold read requests for 6 cycles → grants 0,1,0,1,0,1. Responses alternate with 1-cycle latency, and rsp_valid is never high on both at once.
- Partial write: addr 5 holds 0x11223344. Req 1 writes 0xAABBCCDD with bwen=4'b0101 → a read of addr 5 returns 0x11BB33DD.
- Idle cycles between requests: prio holds. From prio=1, a single valid on req 0 is granted immediately, and prio becomes 1.
- Reset asserted the cycle after a read is accepted → no rsp_valid. After release, all outputs are 0, prio = 0, and a read of any address returns 0.
- Back-to-back write then read of the same address from different requesters → the read returns the freshly written data.
